// File: rtl/syst_pkg.sv
// rtl/syst_pkg.sv - shared defaults and the result narrowing helper for the skew bridge
package syst_pkg;

  localparam int LANES_DEF      = 4;
  localparam int X_W_DEF        = 8;
  localparam int Y_W_DEF        = 20;
  localparam int OUT_W_DEF      = 8;
  localparam int ARRAY_LAT_DEF  = 4;
  localparam int FIFO_DEPTH_DEF = 16;

  // Widest array result the narrowing helper handles.
  localparam int SAT_MAX_W = 64;

  typedef enum logic {
    NARROW_TRUNC = 1'b0,
    NARROW_SAT   = 1'b1
  } narrow_mode_e;

  // Narrow an unsigned result to out_w bits: clamp to all ones or keep the low bits.
  function automatic logic [SAT_MAX_W-1:0] sat_narrow(input logic [SAT_MAX_W-1:0] y,
                                                      input int out_w,
                                                      input narrow_mode_e mode);
    logic [SAT_MAX_W-1:0] lim;
    lim = (SAT_MAX_W'(1) << out_w) - SAT_MAX_W'(1);
    if (mode == NARROW_SAT && y > lim) sat_narrow = lim;
    else sat_narrow = y & lim;
  endfunction

endpackage

// File: rtl/syst_out_fifo.sv
// rtl/syst_out_fifo.sv - synchronous FIFO with registered show-ahead output and occupancy count
module syst_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    mem_cnt;
  logic             load;

  // The output register refills from storage whenever it is empty or being drained.
  assign load  = (mem_cnt != '0) && (!valid || pop);
  assign count = mem_cnt + CW'(valid);
  assign full  = (count == CW'(DEPTH));

  // Storage array carries no reset; only its pointers matter after reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= push_data;
  end

  // Pointers, storage occupancy and the show-ahead output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      valid   <= 1'b0;
      data    <= '0;
    end else begin
      if (push) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
      if (load) rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
      mem_cnt <= mem_cnt + CW'(push) - CW'(load);
      if (load) begin
        valid <= 1'b1;
        data  <= mem[rptr];
      end else if (pop) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/syst_skew_bridge.sv
// rtl/syst_skew_bridge.sv - skews lanes into a systolic array, deskews and narrows results into a FIFO
module syst_skew_bridge
  import syst_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int X_W        = X_W_DEF,
  parameter int Y_W        = Y_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int ARRAY_LAT  = ARRAY_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [LANES*X_W-1:0]   data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   sat_en_i,
  output logic [LANES*X_W-1:0]   arr_x_o,
  output logic [LANES-1:0]       arr_valid_o,
  input  logic [LANES*Y_W-1:0]   arr_y_i,
  output logic [LANES*OUT_W-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  // vpipe[i] marks a beat accepted i edges ago; the last tap is the FIFO push.
  localparam int VP_LEN = ARRAY_LAT + LANES + 1;
  localparam int CW     = $clog2(FIFO_DEPTH+1);
  localparam int IW     = CW + 1;

  logic                   alive;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic [CW-1:0]          fifo_count;
  logic [IW-1:0]          inflight;
  logic [VP_LEN-1:0]      vpipe;
  logic [LANES*OUT_W-1:0] narrowed;
  narrow_mode_e           mode;

  // Credits cover every beat between acceptance and its FIFO slot, so the array never stalls.
  assign ready_o = alive && ((inflight + IW'(fifo_count)) < IW'(FIFO_DEPTH));
  assign accept  = valid_i && ready_o;
  assign push    = vpipe[VP_LEN-1];
  assign pop     = valid_o && ready_i;
  assign mode    = sat_en_i ? NARROW_SAT : NARROW_TRUNC;

  // Beat-valid shift chain, in-flight credit counter and the post-reset ready enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alive    <= 1'b0;
      vpipe    <= '0;
      inflight <= '0;
    end else begin
      alive <= 1'b1;
      vpipe <= {vpipe[VP_LEN-2:0], accept};
      case ({accept, push})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [X_W-1:0] skew_q [0:k];
    logic [Y_W-1:0] desk_q [0:LANES-1-k];

    // Lane k: input reg plus k skew regs before the array, then LANES-1-k deskew regs after it.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int j = 0; j <= k; j++) skew_q[j] <= '0;
        for (int j = 0; j < LANES-k; j++) desk_q[j] <= '0;
      end else begin
        if (accept) skew_q[0] <= data_i[k*X_W +: X_W];
        for (int j = 1; j <= k; j++) begin
          if (vpipe[j-1]) skew_q[j] <= skew_q[j-1];
        end
        if (vpipe[k+ARRAY_LAT]) desk_q[0] <= arr_y_i[k*Y_W +: Y_W];
        for (int j = 1; j < LANES-k; j++) begin
          if (vpipe[k+ARRAY_LAT+j]) desk_q[j] <= desk_q[j-1];
        end
      end
    end

    assign arr_x_o[k*X_W +: X_W]      = skew_q[k];
    assign arr_valid_o[k]             = vpipe[k];
    assign narrowed[k*OUT_W +: OUT_W] = OUT_W'(sat_narrow(SAT_MAX_W'(desk_q[LANES-1-k]), OUT_W, mode));
  end

  syst_out_fifo #(
    .WIDTH (LANES*OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (narrowed),
    .pop       (pop),
    .data      (data_o),
    .valid     (valid_o),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // The credit scheme must make a push into a full, non-draining FIFO impossible.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_syst_skew_bridge.sv
// tb/tb_syst_skew_bridge.sv - randomized self-checking bench for syst_skew_bridge
module tb_syst_skew_bridge;

  localparam int LANES = 4, X_W = 8, Y_W = 20, OUT_W = 8, ARRAY_LAT = 4, FIFO_DEPTH = 16;
  localparam int LAT = ARRAY_LAT + LANES + 2;
  localparam int LANES8 = 8, ARRAY_LAT8 = 6;
  localparam int LAT8 = ARRAY_LAT8 + LANES8 + 2;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [LANES*X_W-1:0]   data_i = '0;
  logic                   valid_i = 1'b0;
  logic                   ready_o;
  logic                   sat_en_i = 1'b1;
  logic [LANES*X_W-1:0]   arr_x;
  logic [LANES-1:0]       arr_valid_o;
  logic [LANES*Y_W-1:0]   arr_y;
  logic [LANES*OUT_W-1:0] data_o;
  logic                   valid_o;
  logic                   ready_i = 1'b1;

  logic [LANES8*X_W-1:0]   data8 = '0;
  logic                    valid8 = 1'b0;
  logic                    ready_o8;
  logic                    sat8 = 1'b1;
  logic [LANES8*X_W-1:0]   arr_x8;
  logic [LANES8-1:0]       arr_valid8;
  logic [LANES8*Y_W-1:0]   arr_y8;
  logic [LANES8*OUT_W-1:0] data_o8;
  logic                    valid_o8;
  logic                    ready_i8 = 1'b1;

  syst_skew_bridge u_dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .sat_en_i(sat_en_i), .arr_x_o(arr_x), .arr_valid_o(arr_valid_o), .arr_y_i(arr_y),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  syst_skew_bridge #(.LANES(LANES8), .ARRAY_LAT(ARRAY_LAT8)) u_dut8 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data8), .valid_i(valid8), .ready_o(ready_o8),
    .sat_en_i(sat8), .arr_x_o(arr_x8), .arr_valid_o(arr_valid8), .arr_y_i(arr_y8),
    .data_o(data_o8), .valid_o(valid_o8), .ready_i(ready_i8)
  );

  // Array model: y_k = 3 * x_k, presented ARRAY_LAT cycles later.
  function automatic logic [159:0] triple(input logic [63:0] x, input int lanes);
    logic [159:0] r;
    r = '0;
    for (int k = 0; k < lanes; k++) r[k*Y_W +: Y_W] = Y_W'(3 * int'(x[k*X_W +: X_W]));
    return r;
  endfunction

  // Expected output beat: 3*x per lane, clamped to 255 or reduced mod 256.
  function automatic logic [63:0] model_out(input logic [63:0] x, input int lanes, input logic sat);
    logic [63:0] r;
    int y;
    r = '0;
    for (int k = 0; k < lanes; k++) begin
      y = 3 * int'(x[k*8 +: 8]);
      if (sat && y > 255) r[k*8 +: 8] = 8'hFF;
      else r[k*8 +: 8] = 8'(y % 256);
    end
    return r;
  endfunction

  logic [LANES*Y_W-1:0]  apipe  [ARRAY_LAT];
  logic [LANES8*Y_W-1:0] apipe8 [ARRAY_LAT8];
  always @(posedge clk) begin
    for (int s = ARRAY_LAT-1; s > 0; s--) apipe[s] <= apipe[s-1];
    apipe[0] <= (LANES*Y_W)'(triple(64'(arr_x), LANES));
    for (int s = ARRAY_LAT8-1; s > 0; s--) apipe8[s] <= apipe8[s-1];
    apipe8[0] <= (LANES8*Y_W)'(triple(arr_x8, LANES8));
  end
  assign arr_y  = apipe[ARRAY_LAT-1];
  assign arr_y8 = apipe8[ARRAY_LAT8-1];

  // Scoreboard capture: accepted beats (with their edge) and delivered beats (with their edge).
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          acc_cyc_q[$];
  int          got_cyc_q[$];
  always @(negedge clk) begin
    if (!rst_i) begin
      if (valid_i && ready_o) begin
        acc_cyc_q.push_back(cyc + 1);
        exp_q.push_back(32'(model_out(64'(data_i), LANES, sat_en_i)));
      end
      if (valid_o && ready_i) begin
        got_q.push_back(data_o);
        got_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); acc_cyc_q.delete(); got_cyc_q.delete();
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit acc;
    int n;
    n = 0;
    valid_i = 1'b1;
    data_i  = d;
    do begin
      acc = ready_o;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    valid_i = 1'b0;
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL send_beat: not accepted within %0d cycles", n);
    end
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int i;
    i = 0;
    while (got_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
    n_checks++; if (arr_valid_o !== '0) begin n_errors++; $display("FAIL reset_arr_valid: got %b want 0", arr_valid_o); end
    n_checks++; if (data_o !== '0) begin n_errors++; $display("FAIL reset_data_o: got %h want 0", data_o); end
    n_checks++; if (arr_x !== '0) begin n_errors++; $display("FAIL reset_arr_x: got %h want 0", arr_x); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_ready_in_reset: got %b want 0", ready_o); end
    rst_i = 1'b0;
    #1;
    n_checks++; if (ready_o !== 1'b0) begin n_errors++; $display("FAIL reset_ready_before_edge: got %b want 0", ready_o); end
    @(posedge clk); #1;
    n_checks++; if (ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready_after_edge: got %b want 1", ready_o); end
    clear_sb();
  endtask

  task automatic test_single_beat();
    logic [31:0] x;
    logic [LANES-1:0] ev;
    x = 32'h04030201;
    sat_en_i = 1'b1;
    ready_i  = 1'b1;
    send_beat(x);
    for (int k = 0; k < LANES; k++) begin
      ev = LANES'(1 << k);
      n_checks++;
      if (arr_valid_o !== ev) begin n_errors++; $display("FAIL skew_valid lane%0d: got %b want %b", k, arr_valid_o, ev); end
      n_checks++;
      if (arr_x[k*X_W +: X_W] !== x[k*X_W +: X_W]) begin
        n_errors++; $display("FAIL skew_data lane%0d: got %h want %h", k, arr_x[k*X_W +: X_W], x[k*X_W +: X_W]);
      end
      @(posedge clk); #1;
    end
    wait_outputs(1, 40);
    n_checks++;
    if (got_q.size() != 1) begin
      n_errors++; $display("FAIL single_count: got %0d beats want 1", got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== 32'h0C090603) begin n_errors++; $display("FAIL single_data: got %h want 0c090603", got_q[0]); end
      n_checks++;
      if (got_cyc_q[0] - acc_cyc_q[0] != LAT) begin
        n_errors++; $display("FAIL single_latency: got %0d want %0d", got_cyc_q[0] - acc_cyc_q[0], LAT);
      end
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != 1) begin n_errors++; $display("FAIL single_idle: got %0d beats want 1", got_q.size()); end
    clear_sb();
  endtask

  task automatic test_saturation();
    logic [7:0] xs  [4] = '{8'h61, 8'h61, 8'h55, 8'h55};
    logic       sat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] want[4] = '{8'hFF, 8'h23, 8'hFF, 8'hFF};
    logic [31:0] d;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sat_en_i = sat[i];
      d = {$urandom_range(0, 255) % 256, 8'h00, 8'h00, 8'h00} | {8'h00, 8'($urandom), 8'($urandom), xs[i]};
      send_beat(d);
      wait_outputs(1, 40);
      n_checks++;
      if (got_q.size() != 1) begin
        n_errors++; $display("FAIL sat_count case%0d: got %0d want 1", i, got_q.size());
      end else begin
        n_checks++;
        if (got_q[0][7:0] !== want[i]) begin
          n_errors++; $display("FAIL sat_lane0 case%0d: got %h want %h", i, got_q[0][7:0], want[i]);
        end
        n_checks++;
        if (got_q[0] !== exp_q[0]) begin
          n_errors++; $display("FAIL sat_beat case%0d: got %h want %h", i, got_q[0], exp_q[0]);
        end
      end
      clear_sb();
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [31:0] g, e;
    ready_i  = 1'b0;
    sat_en_i = 1'($urandom_range(0, 1));
    valid_i  = 1'b1;
    data_i   = $urandom;
    for (int i = 0; i < 40; i++) begin
      acc = ready_o;
      @(posedge clk); #1;
      if (acc) data_i = $urandom;
    end
    valid_i = 1'b0;
    n_checks++;
    if (acc_cyc_q.size() != FIFO_DEPTH) begin
      n_errors++; $display("FAIL bp_accepted: got %0d want %0d", acc_cyc_q.size(), FIFO_DEPTH);
    end
    n_checks++;
    if (ready_o !== 1'b0) begin n_errors++; $display("FAIL bp_ready_low: got %b want 0", ready_o); end
    ready_i = 1'b1;
    wait_outputs(FIFO_DEPTH, 80);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() != FIFO_DEPTH) begin
      n_errors++; $display("FAIL bp_drained: got %0d want %0d", got_q.size(), FIFO_DEPTH);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL bp_order: got %h want %h", g, e); end
    end
    n_checks++;
    if (ready_o !== 1'b1) begin n_errors++; $display("FAIL bp_ready_back: got %b want 1", ready_o); end
    clear_sb();
  endtask

  task automatic test_back_to_back();
    bit acc;
    int ready_low, n;
    logic [31:0] g, e;
    ready_i   = 1'b1;
    sat_en_i  = 1'b1;
    ready_low = 0;
    n = 0;
    valid_i = 1'b1;
    data_i  = $urandom;
    while (acc_cyc_q.size() < 100 && n < 200) begin
      if (!ready_o) ready_low++;
      acc = ready_o;
      @(posedge clk); #1;
      n++;
      if (acc) data_i = $urandom;
    end
    valid_i = 1'b0;
    n_checks++;
    if (ready_low != 0) begin n_errors++; $display("FAIL b2b_ready_drop: got %0d low cycles want 0", ready_low); end
    wait_outputs(100, 60);
    n_checks++;
    if (got_q.size() != 100) begin
      n_errors++; $display("FAIL b2b_count: got %0d want 100", got_q.size());
    end else begin
      n_checks++;
      if (got_cyc_q[0] - acc_cyc_q[0] != LAT) begin
        n_errors++; $display("FAIL b2b_first_latency: got %0d want %0d", got_cyc_q[0] - acc_cyc_q[0], LAT);
      end
      n_checks++;
      if (got_cyc_q[99] - got_cyc_q[0] != 99) begin
        n_errors++; $display("FAIL b2b_consecutive: got span %0d want 99", got_cyc_q[99] - got_cyc_q[0]);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL b2b_data: got %h want %h", g, e); end
    end
    clear_sb();
  endtask

  task automatic test_random_ready();
    bit acc;
    int n, n_acc;
    logic [31:0] g, e;
    sat_en_i = 1'($urandom_range(0, 1));
    valid_i  = 1'b1;
    data_i   = $urandom;
    ready_i  = 1'($urandom_range(0, 1));
    n = 0;
    while (acc_cyc_q.size() < 200 && n < 3000) begin
      acc = valid_i && ready_o;
      @(posedge clk); #1;
      n++;
      if (acc || !valid_i) begin
        data_i  = $urandom;
        valid_i = ($urandom_range(0, 9) < 7);
      end
      ready_i = 1'($urandom_range(0, 1));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    n_acc = acc_cyc_q.size();
    wait_outputs(n_acc, 100);
    n_checks++;
    if (n_acc != 200 || got_q.size() != n_acc) begin
      n_errors++; $display("FAIL rnd_count: accepted %0d delivered %0d want 200 each", n_acc, got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL rnd_order: got %h want %h", g, e); end
    end
    clear_sb();
  endtask

  task automatic test_reset_midstream();
    int seen;
    ready_i  = 1'b0;
    sat_en_i = 1'b1;
    for (int i = 0; i < 3; i++) send_beat($urandom);
    repeat (12) @(posedge clk);
    #1;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i = $urandom;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b1) begin n_errors++; $display("FAIL rst_pre_valid_o: got %b want 1", valid_o); end
    n_checks++;
    if (arr_valid_o === '0) begin n_errors++; $display("FAIL rst_pre_arr_valid: got %b want nonzero", arr_valid_o); end
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_async_valid_o: got %b want 0", valid_o); end
    n_checks++;
    if (arr_valid_o !== '0) begin n_errors++; $display("FAIL rst_async_arr_valid: got %b want 0", arr_valid_o); end
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    clear_sb();
    ready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid_o || arr_valid_o != '0) seen++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (seen != 0 || got_q.size() != 0) begin
      n_errors++; $display("FAIL rst_no_output: got %0d active cycles %0d beats want 0", seen, got_q.size());
    end
    n_checks++;
    if (ready_o !== 1'b1) begin n_errors++; $display("FAIL rst_ready_after: got %b want 1", ready_o); end
    clear_sb();
  endtask

  task automatic test_credit_edge();
    logic [31:0] g, e;
    ready_i  = 1'b0;
    sat_en_i = 1'b0;
    valid_i  = 1'b1;
    for (int i = 0; i < FIFO_DEPTH-2; i++) begin
      data_i = $urandom;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    valid_i = 1'b1;
    data_i  = $urandom;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin n_errors++; $display("FAIL credit_ready_before: got %b want 1", ready_o); end
    valid_i = 1'b1;
    data_i  = $urandom;
    @(posedge clk); #1;
    valid_i = 1'b0;
    n_checks++;
    if (acc_cyc_q.size() != FIFO_DEPTH) begin
      n_errors++; $display("FAIL credit_accepted: got %0d want %0d", acc_cyc_q.size(), FIFO_DEPTH);
    end
    n_checks++;
    if (ready_o !== 1'b0) begin n_errors++; $display("FAIL credit_ready_full: got %b want 0", ready_o); end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    n_checks++;
    if (ready_o !== 1'b1) begin n_errors++; $display("FAIL credit_ready_after_pop: got %b want 1", ready_o); end
    ready_i = 1'b1;
    wait_outputs(FIFO_DEPTH, 80);
    n_checks++;
    if (got_q.size() != FIFO_DEPTH) begin
      n_errors++; $display("FAIL credit_drained: got %0d want %0d", got_q.size(), FIFO_DEPTH);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL credit_order: got %h want %h", g, e); end
    end
    clear_sb();
  endtask

  task automatic test_wide_config();
    logic [63:0] x, e;
    int n;
    ready_i8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sat8 = (i == 0);
      x = {$urandom, $urandom};
      e = model_out(x, LANES8, sat8);
      data8  = x;
      valid8 = 1'b1;
      n_checks++;
      if (ready_o8 !== 1'b1) begin n_errors++; $display("FAIL wide_ready: got %b want 1", ready_o8); end
      @(posedge clk); #1;
      valid8 = 1'b0;
      n = 0;
      while (n < 40) begin
        @(posedge clk); #1;
        n++;
        if (valid_o8) break;
      end
      n_checks++;
      if (n != LAT8) begin n_errors++; $display("FAIL wide_latency run%0d: got %0d want %0d", i, n, LAT8); end
      n_checks++;
      if (data_o8 !== e) begin n_errors++; $display("FAIL wide_data run%0d: got %h want %h", i, data_o8, e); end
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_random_ready();
    test_reset_midstream();
    test_credit_edge();
    test_wide_config();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
